// File: rtl/int_to_float_if.sv
// Operand/result handshake bundle for the int-to-float converter.
// Both channels use the float library's stb/ack protocol: a transfer happens
// on a rising clock edge where the producer's stb and the consumer's ack are
// both high.
interface int_to_float_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  // Upstream driver / downstream consumer side.
  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  // Converter side.
  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/int_to_float_sequential.sv
// Multi-cycle 32-bit two's-complement integer to IEEE-754 binary32 converter,
// round-to-nearest-even, with stb/ack handshakes on operand and result.
// Normalisation shifts one bit per cycle by default. Defining
// INT_TO_FLOAT_LEAD_ZERO_EN replaces the serial shifter with a leading-zero
// counter and a barrel shift, so normalisation takes a single cycle. Results
// are the same in both builds.
module int_to_float_sequential (
  input  logic            clk,
  input  logic            rst,
  int_to_float_if.slave   bus
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t             state;
  logic        [31:0] a;
  logic               sign;
  logic        [31:0] mag;
  logic signed [9:0]  exp;
  logic        [22:0] frac;

  // After normalisation mag[31] is the hidden one, so the 24-bit significand
  // carries out only when mag[31:8] is all ones. The 23-bit fraction increment
  // then wraps to zero, which is exactly the fraction of 0x800000.
  logic        [22:0] frac_inc;
  logic               round_up;
  logic               carry;
  logic        [7:0]  exp_biased;

  assign frac_inc   = mag[30:8] + 23'd1;
  assign round_up   = mag[7] && (mag[6] || (|mag[5:0]) || mag[8]);
  assign carry      = round_up && (&mag[30:8]);
  assign exp_biased = exp[7:0] + 8'd127;

`ifdef INT_TO_FLOAT_LEAD_ZERO_EN
  logic [4:0] lz;

  // Priority leading-zero count of the magnitude; the highest set bit wins.
  always_comb begin
    // NOTE: default assignment first so every path drives lz and no latch is inferred.
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lz = 5'(31 - i);
    end
  end
`endif

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= GET_A;
      a                <= '0;
      sign             <= 1'b0;
      mag              <= '0;
      exp              <= '0;
      frac             <= '0;
      bus.input_a_ack  <= 1'b0;
      bus.output_z     <= '0;
      bus.output_z_stb <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
      case (state)
        GET_A: begin
          bus.input_a_ack <= 1'b1;
          if (bus.input_a_ack && bus.input_a_stb) begin
            a               <= bus.input_a;
            bus.input_a_ack <= 1'b0;
            state           <= CONVERT;
          end
        end

        CONVERT: begin
          if (a == 32'd0) begin
            bus.output_z <= 32'd0;
            state        <= PUT_Z;
          end else begin
            sign  <= a[31];
            // 0x80000000 negates to itself, which is the correct magnitude.
            mag   <= a[31] ? (~a + 32'd1) : a;
            exp   <= 10'sd31;
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
`ifdef INT_TO_FLOAT_LEAD_ZERO_EN
          mag   <= mag << lz;
          exp   <= 10'sd31 - $signed({5'd0, lz});
          state <= ROUND;
`else
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 10'sd1;
          end
`endif
        end

        ROUND: begin
          frac <= round_up ? frac_inc : mag[30:8];
          if (carry) exp <= exp + 10'sd1;
          state <= PACK;
        end

        PACK: begin
          // Exponent tops out at 158, so the biased value always fits.
          bus.output_z     <= {sign, exp_biased, frac};
          bus.output_z_stb <= 1'b1;
          state            <= PUT_Z;
        end

        PUT_Z: begin
          bus.output_z_stb <= 1'b1;
          if (bus.output_z_stb && bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= GET_A;
          end
        end

        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_sequential.sv
// Self-checking bench for int_to_float_sequential. A reference model derived
// from the IEEE-754 rounding rules predicts each result and its latency; one
// monitor compares the DUT against it on every negative clock edge.
module tb_int_to_float_sequential;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int_to_float_if bus();

  int_to_float_sequential dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] z;
    int          cap;
    int          lat;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          xfers    = 0;
  logic [31:0] last_z   = '0;
  exp_t        pend[$];
  exp_t        ent;
  bit          seen_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Index of the most significant set bit of a nonzero magnitude.
  function automatic int msb_pos(input longint mag);
    int p = 0;
    for (int i = 0; i < 33; i++) begin
      if (mag >= (64'sd1 << i)) p = i;
    end
    return p;
  endfunction

  function automatic longint abs_val(input logic [31:0] v);
    longint m = longint'($signed(v));
    return (m < 0) ? -m : m;
  endfunction

  // Exact integer value rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint mag, q, rem, half;
    int     p, shift, e;
    if (v == 32'd0) return 32'd0;
    mag = abs_val(v);
    p   = msb_pos(mag);
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      shift = p - 23;
      q     = mag >> shift;
      rem   = mag - (q << shift);
      half  = 64'sd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = p + 127;
    return {v[31], e[7:0], q[22:0]};
  endfunction

  // Edges from capture to the first edge with output_z_stb high.
  function automatic int ref_latency(input logic [31:0] v);
    if (v == 32'd0) return 2;
`ifdef INT_TO_FLOAT_LEAD_ZERO_EN
    return 4;
`else
    return (31 - msb_pos(abs_val(v))) + 4;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: result value, latency, idle stb, and capture bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      seen_first = 1'b0;
    end else begin
      if (pend.size() == 0) begin
        check("idle_stb", {31'd0, bus.output_z_stb}, 32'd0);
      end else if (bus.output_z_stb) begin
        check("result", bus.output_z, pend[0].z);
        if (!seen_first) begin
          check("latency", 32'(cyc - pend[0].cap), 32'(pend[0].lat));
          seen_first = 1'b1;
        end
        if (bus.output_z_ack) begin
          last_z = bus.output_z;
          xfers++;
          void'(pend.pop_front());
          seen_first = 1'b0;
        end
      end
      if (bus.input_a_stb && bus.input_a_ack) begin
        ent.z   = ref_float(bus.input_a);
        ent.cap = cyc + 1;
        ent.lat = ref_latency(bus.input_a);
        pend.push_back(ent);
      end
    end
  end

  task automatic send(input logic [31:0] v);
    int n = 0;
    bus.input_a     = v;
    bus.input_a_stb = 1'b1;
    @(negedge clk);
    while (!bus.input_a_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ack", {31'd0, bus.input_a_ack}, 32'd1);
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(pend.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_v [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                             32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'h00000064};
  logic [31:0] dir_z [8] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000,
                             32'h4B800000, 32'h4B800002, 32'h4F000000, 32'h42C80000};

  initial begin
    logic [31:0] v;
    int          n;
    int          xb;

    bus.input_a      = '0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b1;

    // Hand-computed values pin the reference model.
    for (int i = 0; i < 8; i++) check("model", ref_float(dir_v[i]), dir_z[i]);

    // Reset state and first ack edge.
    #1 rst = 1'b1;
    #1;
    check("rst_ack", {31'd0, bus.input_a_ack}, 32'd0);
    check("rst_stb", {31'd0, bus.output_z_stb}, 32'd0);
    check("rst_z", bus.output_z, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ack_before_edge", {31'd0, bus.input_a_ack}, 32'd0);
    @(negedge clk);
    check("ack_after_edge", {31'd0, bus.input_a_ack}, 32'd1);

    // Directed vectors, one at a time.
    for (int i = 0; i < 8; i++) begin
      send(dir_v[i]);
      wait_idle();
      check("directed", last_z, dir_z[i]);
    end

    // Backpressure: result held, input refused, then exactly one transfer.
    bus.output_z_ack = 1'b0;
    send(32'h01000003);
    n = 0;
    while (!bus.output_z_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_stb_rise", {31'd0, bus.output_z_stb}, 32'd1);
    @(posedge clk);
    #1;
    bus.input_a     = 32'h12345678;
    bus.input_a_stb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_stb_hold", {31'd0, bus.output_z_stb}, 32'd1);
      check("bp_z_hold", bus.output_z, 32'h4B800002);
      check("bp_in_ack", {31'd0, bus.input_a_ack}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    xb = xfers;
    @(negedge clk);
    @(negedge clk);
    check("bp_single_xfer", 32'(xfers - xb), 32'd1);
    check("bp_stb_drop", {31'd0, bus.output_z_stb}, 32'd0);
    check("bp_ack_low", {31'd0, bus.input_a_ack}, 32'd0);
    @(negedge clk);
    check("bp_ack_back", {31'd0, bus.input_a_ack}, 32'd1);
    check("bp_last", last_z, 32'h4B800002);
    @(posedge clk);
    #1;

    // Reset during normalisation aborts with no result.
    send(32'h00000001);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_stb", {31'd0, bus.output_z_stb}, 32'd0);
    check("abort_ack", {31'd0, bus.input_a_ack}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_ack", {31'd0, bus.input_a_ack}, 32'd0);
      check("abort_hold_stb", {31'd0, bus.output_z_stb}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    xb = xfers;
    send(32'h00000064);
    wait_idle();
    check("after_abort", last_z, 32'h42C80000);
    check("after_abort_cnt", 32'(xfers - xb), 32'd1);

    // Back-to-back signed operands with a spread of leading-zero counts.
    bus.output_z_ack = 1'b1;
    repeat (1500) begin
      v = $urandom;
      v = $signed(v) >>> $urandom_range(0, 31);
      send(v);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
